tick_gen_multi: RTL
===================

TICK_GEN_MULTI -- requirements
Module: tick_gen_multi

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent tick channels.
REQ-002 Parameter CNT_W, default 20: width of each divisor and counter.
REQ-003 Parameter DIV_RESET, default 50000: divisor loaded into every channel at reset (1 kHz from 50 MHz).
REQ-004 clk_50MHz  input  1  system clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 ch_enable  input  NUM_CH  per-channel run enable, level-sensitive.
REQ-007 ch_oneshot  input  NUM_CH  per-channel mode: 1 = one-shot, 0 = periodic.
REQ-008 div_load  input  NUM_CH  per-channel divisor write strobe, one cycle.
REQ-009 div_value  input  CNT_W  divisor value shared by all div_load bits.
REQ-010 sync_clr  input  1  global phase-align strobe.
REQ-011 tick  output  NUM_CH  one-cycle enable pulse per channel, registered.
REQ-012 running  output  NUM_CH  channel counting (enabled and not one-shot done), registered.
REQ-013 cfg_err  output  1  sticky flag: a zero divisor was written.

Function
REQ-014 Each channel SHALL hold div_reg, pend_reg, pend_valid, cnt and done; channels SHALL be fully independent except for div_value and sync_clr.
REQ-015 Counting: when running, each edge: if cnt >= div_reg-1 then cnt <= 0 and tick <= 1, else cnt <= cnt+1 and tick <= 0.
REQ-016 From cnt = 0, first tick SHALL be high in the cycle after the div_reg-th enabled edge; period exactly div_reg cycles.
REQ-017 div_reg = 1 SHALL hold tick continuously high while running.
REQ-018 ch_enable low: cnt <= 0, tick <= 0, done <= 0, running <= 0 on the next edge.
REQ-019 One-shot mode: on the terminal-count edge, tick pulses once and done <= 1; running SHALL drop in the same cycle tick is high; no further ticks until ch_enable is low for at least one edge and then high again.
REQ-020 Changing ch_oneshot while running SHALL take effect at the next terminal count.
REQ-021 div_load with nonzero div_value, channel not running: div_reg <= div_value and cnt <= 0 immediately.
REQ-022 div_load with nonzero div_value, channel running: pend_reg <= div_value, pend_valid <= 1; current period completes with the old divisor.
REQ-023 At a terminal-count edge with pend_valid set, div_reg <= pend_reg and pend_valid <= 0; the next period uses the new divisor.
REQ-024 div_load coinciding with the terminal-count edge: div_value SHALL be applied directly to div_reg for the next period; pend_valid <= 0.
REQ-025 A second div_load before the pending value is applied SHALL overwrite pend_reg (last write wins).
REQ-026 div_load with div_value = 0 SHALL be ignored, with no state change in the channel, and SHALL set cfg_err <= 1.
REQ-027 sync_clr SHALL take priority over counting and div_load: every channel cnt <= 0, tick <= 0, pending divisor applied, done <= 0.
REQ-028 After sync_clr, all enabled channels with equal div_reg SHALL tick on the same edge.
REQ-029 Counter comparison SHALL use >=, so a divisor decrease below the current cnt (non-running load) cannot miss terminal count.

Reset
REQ-030 rst_n low SHALL asynchronously set: tick = 0, running = 0, cfg_err = 0, cnt = 0, done = 0, pend_valid = 0, div_reg = DIV_RESET, pend_reg = DIV_RESET.
REQ-031 Release of rst_n SHALL be used synchronously; the first counting edge is the first rising edge with rst_n high and ch_enable high.
REQ-032 Reset asserted mid-period or mid-pending-load SHALL discard all in-flight state.

Verification (DIV_RESET = 5, NUM_CH = 4, CNT_W = 8)
REQ-033 Reset release, ch_enable = 4'b0001, periodic -> tick[0] high for one cycle every 5 cycles, first after the 5th edge; tick[3:1] stay 0.
REQ-034 Ch0 running, div_load[0] with value 3 at cnt = 1 -> current period ends at 5 cycles; next periods are 3 cycles; a load on the terminal edge applies immediately.
REQ-035 Ch1 one-shot, div 4 -> exactly one tick, after the 4th edge; running[1] low in the tick cycle; toggle ch_enable[1] 1->0->1 -> one more tick 4 edges later.
REQ-036 Ch0 div 5, ch2 div 5 enabled with different phases; pulse sync_clr -> both tick together 5 edges later and every 5 thereafter.
REQ-037 div_load[3] with value 0 -> cfg_err = 1 and ch3 period unchanged; div_load[3] with value 1 -> tick[3] constantly high; rst_n low mid-period -> all outputs 0 at once and cfg_err cleared.

Source files
------------

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator: each channel divides clk_50MHz by its own
// divisor and emits one-cycle enable pulses, periodic or one-shot, with glitch-free reloads.
module tick_gen_multi #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 20,
  parameter int DIV_RESET = 50000
) (
  input  logic              clk_50MHz,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic [NUM_CH-1:0] ch_oneshot,
  input  logic [NUM_CH-1:0] div_load,
  input  logic [CNT_W-1:0]  div_value,
  input  logic              sync_clr,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] running,
  output logic              cfg_err
);

  logic [CNT_W-1:0]  div_q      [NUM_CH];
  logic [CNT_W-1:0]  div_d      [NUM_CH];
  logic [CNT_W-1:0]  pend_q     [NUM_CH];
  logic [CNT_W-1:0]  pend_d     [NUM_CH];
  logic [CNT_W-1:0]  cnt_q      [NUM_CH];
  logic [CNT_W-1:0]  cnt_d      [NUM_CH];
  logic [NUM_CH-1:0] pend_vld_q, pend_vld_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] run_q, run_d;
  logic              cfg_err_q, cfg_err_d;

  logic              value_ok;
  logic [NUM_CH-1:0] load_ok;
  logic [NUM_CH-1:0] term;

  assign value_ok = (div_value != '0);

  // >= rather than == so a counter stranded above a shrunken divisor still wraps
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign load_ok[g] = div_load[g] & value_ok;
    assign term[g]    = (cnt_q[g] >= (div_q[g] - CNT_W'(1)));
  end

  always_comb begin
    cfg_err_d = cfg_err_q | ((|div_load) & ~value_ok);
    for (int i = 0; i < NUM_CH; i++) begin
      div_d[i]      = div_q[i];
      pend_d[i]     = pend_q[i];
      cnt_d[i]      = cnt_q[i];
      pend_vld_d[i] = pend_vld_q[i];
      done_d[i]     = done_q[i];
      tick_d[i]     = 1'b0;
      if (sync_clr) begin
        cnt_d[i]  = '0;
        done_d[i] = 1'b0;
        if (pend_vld_q[i]) begin
          div_d[i]      = pend_q[i];
          pend_vld_d[i] = 1'b0;
        end
      end else if (!ch_enable[i]) begin
        cnt_d[i]  = '0;
        done_d[i] = 1'b0;
        if (load_ok[i]) begin
          div_d[i]      = div_value;
          pend_vld_d[i] = 1'b0;
        end
      end else if (done_q[i]) begin
        if (load_ok[i]) begin
          div_d[i]      = div_value;
          cnt_d[i]      = '0;
          pend_vld_d[i] = 1'b0;
        end
      end else if (term[i]) begin
        cnt_d[i]      = '0;
        tick_d[i]     = 1'b1;
        done_d[i]     = ch_oneshot[i];
        pend_vld_d[i] = 1'b0;
        // A load landing on the terminal edge beats any older pending value
        if (load_ok[i]) begin
          div_d[i] = div_value;
        end else if (pend_vld_q[i]) begin
          div_d[i] = pend_q[i];
        end
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
        if (load_ok[i]) begin
          pend_d[i]     = div_value;
          pend_vld_d[i] = 1'b1;
        end
      end
      run_d[i] = ch_enable[i] & ~done_d[i];
    end
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]  <= CNT_W'(DIV_RESET);
        pend_q[i] <= CNT_W'(DIV_RESET);
        cnt_q[i]  <= '0;
      end
      pend_vld_q <= '0;
      done_q     <= '0;
      tick_q     <= '0;
      run_q      <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]  <= div_d[i];
        pend_q[i] <= pend_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      pend_vld_q <= pend_vld_d;
      done_q     <= done_d;
      tick_q     <= tick_d;
      run_q      <= run_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign tick    = tick_q;
  assign running = run_q;
  assign cfg_err = cfg_err_q;

endmodule
